// File: rtl/dyn_mem_bkgp_rmw_ctrl.sv
// Bank-group SRAM controller: byte-parity storage, sub-word writes
// turned into read-modify-write, fixed one-cycle response latency.
module dyn_mem_bkgp_rmw_ctrl #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 10,
  parameter int ERR_CNT_WIDTH = 16,
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [ADDR_WIDTH-1:0]    addr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [NB-1:0]            strb_i,
  output logic                     gnt_o,
  output logic                     rvalid_o,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     ecc_err_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDR_WIDTH-1:0]    mem_addr_o,
  output logic [DATA_WIDTH+NB-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH+NB-1:0] mem_rdata_i,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

  typedef enum logic {
    IDLE,
    MERGE
  } state_e;

  function automatic logic [NB-1:0] par(
    input logic [DATA_WIDTH-1:0] d
  );
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = ^d[8*b +: 8];
    return p;
  endfunction

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic                  ld;

  logic                     rvalid_q;
  logic                     rd_q;
  logic                     werr_q;
  logic [ERR_CNT_WIDTH-1:0] cnt_q;

  logic [DATA_WIDTH-1:0] merged;
  logic [NB-1:0]         bad;
  logic                  full_w;
  logic                  empty_w;
  logic                  acc;

  assign full_w  = &strb_i;
  assign empty_w = ~|strb_i;
  assign acc     = req_i & gnt_o;

  // Bad bytes of the SRAM word, and the strobe-driven merge
  always_comb begin
    bad    = '0;
    merged = '0;
    for (int b = 0; b < NB; b++) begin
      bad[b] = ^{mem_rdata_i[8*b +: 8],
                 mem_rdata_i[DATA_WIDTH+b]};
      merged[8*b +: 8] = strb_q[b] ?
        wdata_q[8*b +: 8] :
        mem_rdata_i[8*b +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    ld          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          unique case (1'b1)
            !we_i: begin
              gnt_o      = 1'b1;
              mem_req_o  = 1'b1;
              mem_addr_o = addr_i;
            end
            we_i && full_w: begin
              gnt_o       = 1'b1;
              mem_req_o   = 1'b1;
              mem_we_o    = 1'b1;
              mem_addr_o  = addr_i;
              mem_wdata_o = {par(wdata_i), wdata_i};
            end
            we_i && empty_w: begin
              gnt_o = 1'b1;
            end
            default: begin
              mem_req_o  = 1'b1;
              mem_addr_o = addr_i;
              ld         = 1'b1;
              state_d    = MERGE;
            end
          endcase
        end
      end
      MERGE: begin
        gnt_o       = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = {par(merged), merged};
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ld) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        strb_q  <= strb_i;
      end
    end
  end

  // Overwritten bytes are excluded from the partial-write error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rd_q     <= 1'b0;
      werr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rvalid_q <= acc;
      rd_q     <= acc & ~we_i;
      werr_q   <= (state_q == MERGE) & |(bad & ~strb_q);
      if (ecc_err_o && !(&cnt_q))
        cnt_q <= cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  assign rvalid_o  = rvalid_q;
  assign rdata_o   = (rvalid_q & rd_q) ?
                     mem_rdata_i[DATA_WIDTH-1:0] : '0;
  assign ecc_err_o = rvalid_q & (rd_q ? |bad : werr_q);
  assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_dyn_mem_bkgp_rmw_ctrl.sv
// Directed bench for dyn_mem_bkgp_rmw_ctrl with a behavioural
// single-port SRAM (1-cycle read) and a backdoor word injector.
module tb_dyn_mem_bkgp_rmw_ctrl;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam int NB = DW / 8;
  localparam int MW = DW + NB;

  logic          clk;
  logic          rst_ni;
  logic          req_i;
  logic          we_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic [NB-1:0] strb_i;
  logic          gnt_o;
  logic          rvalid_o;
  logic [DW-1:0] rdata_o;
  logic          ecc_err_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [MW-1:0] mem_wdata_o;
  logic [MW-1:0] mem_rdata_i;
  logic [CW-1:0] err_cnt_o;

  logic [MW-1:0] mem [0:(1<<AW)-1];
  logic          inj;
  logic [AW-1:0] inj_addr;
  logic [MW-1:0] inj_data;

  int vec;
  int errs;

  dyn_mem_bkgp_rmw_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .strb_i(strb_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .ecc_err_o(ecc_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .err_cnt_o(err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (inj)
      mem[inj_addr] <= inj_data;
    else if (mem_req_o && mem_we_o)
      mem[mem_addr_o] <= mem_wdata_o;
    if (mem_req_o && !mem_we_o)
      mem_rdata_i <= mem[mem_addr_o];
  end

  function automatic logic [NB-1:0] par(input logic [DW-1:0] d);
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = ^d[8*b +: 8];
    return p;
  endfunction

  task automatic idle_in();
    req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; strb_i = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic inject(input logic [AW-1:0] a, input logic [MW-1:0] w);
    step(); idle_in();
    inj = 1; inj_addr = a; inj_data = w;
    step(); inj = 0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step();
    req_i = 1; we_i = 1; addr_i = a; wdata_i = d; strb_i = '1; #1;
    vec++;
    if (gnt_o !== 1 || mem_we_o !== 1 || mem_wdata_o !== {par(d), d}) begin
      errs++;
      $display("FAIL wr_issue: gnt=%b we=%b wd=%h want gnt=1 we=1 wd=%h",
               gnt_o, mem_we_o, mem_wdata_o, {par(d), d});
    end
    step(); idle_in(); #1;
    vec++;
    if (rvalid_o !== 1 || rdata_o !== '0 || ecc_err_o !== 0) begin
      errs++;
      $display("FAIL wr_rsp: rv=%b rd=%h ecc=%b want 1 0 0",
               rvalid_o, rdata_o, ecc_err_o);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic e);
    step();
    req_i = 1; we_i = 0; addr_i = a; #1;
    vec++;
    if (gnt_o !== 1 || mem_req_o !== 1 || mem_we_o !== 0 ||
        mem_addr_o !== a) begin
      errs++;
      $display("FAIL rd_issue: gnt=%b mreq=%b mwe=%b ma=%h want 1 1 0 %h",
               gnt_o, mem_req_o, mem_we_o, mem_addr_o, a);
    end
    step(); idle_in(); #1;
    vec++;
    if (rvalid_o !== 1 || rdata_o !== d || ecc_err_o !== e) begin
      errs++;
      $display("FAIL rd_rsp: rv=%b rd=%h ecc=%b want 1 %h %b",
               rvalid_o, rdata_o, ecc_err_o, d, e);
    end
  endtask

  task automatic do_partial(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [NB-1:0] s, input logic [DW-1:0] m,
                            input logic e);
    step();
    req_i = 1; we_i = 1; addr_i = a; wdata_i = d; strb_i = s; #1;
    vec++;
    if (gnt_o !== 0 || mem_req_o !== 1 || mem_we_o !== 0 ||
        mem_addr_o !== a) begin
      errs++;
      $display("FAIL pw_read: gnt=%b mreq=%b mwe=%b ma=%h want 0 1 0 %h",
               gnt_o, mem_req_o, mem_we_o, mem_addr_o, a);
    end
    step(); #1;
    vec++;
    if (gnt_o !== 1 || mem_we_o !== 1 || mem_addr_o !== a ||
        mem_wdata_o !== {par(m), m} || rvalid_o !== 0) begin
      errs++;
      $display("FAIL pw_merge: gnt=%b we=%b ma=%h wd=%h rv=%b want 1 1 %h %h 0",
               gnt_o, mem_we_o, mem_addr_o, mem_wdata_o, rvalid_o,
               a, {par(m), m});
    end
    step(); idle_in(); #1;
    vec++;
    if (rvalid_o !== 1 || rdata_o !== '0 || ecc_err_o !== e) begin
      errs++;
      $display("FAIL pw_rsp: rv=%b rd=%h ecc=%b want 1 0 %b",
               rvalid_o, rdata_o, ecc_err_o, e);
    end
  endtask

  task automatic test_reset();
    rst_ni = 0; inj = 0; inj_addr = '0; inj_data = '0; idle_in();
    #23;
    vec++;
    if (gnt_o !== 0 || rvalid_o !== 0 || ecc_err_o !== 0 ||
        mem_req_o !== 0 || mem_we_o !== 0 || rdata_o !== '0 ||
        err_cnt_o !== '0 || mem_addr_o !== '0 || mem_wdata_o !== '0) begin
      errs++;
      $display("FAIL reset: gnt=%b rv=%b ecc=%b mreq=%b mwe=%b rd=%h cnt=%0d want all 0",
               gnt_o, rvalid_o, ecc_err_o, mem_req_o, mem_we_o,
               rdata_o, err_cnt_o);
    end
    @(negedge clk); rst_ni = 1;
  endtask

  task automatic test_full_rw();
    do_write(10'd5, 64'hDEADBEEF_01234567);
    do_read(10'd5, 64'hDEADBEEF_01234567, 1'b0);
  endtask

  task automatic test_partial();
    do_partial(10'd5, 64'hFFFFFFFF_AABBCCDD, 8'h0F,
               64'hDEADBEEF_AABBCCDD, 1'b0);
    do_read(10'd5, 64'hDEADBEEF_AABBCCDD, 1'b0);
  endtask

  task automatic test_parity();
    logic [DW-1:0] d9;
    logic [DW-1:0] m1;
    logic [DW-1:0] m2;
    d9 = 64'h01234567_89ABCDEF;
    m1 = 64'hAA234567_89ABCDEF;
    m2 = 64'hAA234567_89ABCD55;
    do_write(10'd9, d9);
    inject(10'd9, {par(d9) ^ 8'h80, d9});
    do_read(10'd9, d9, 1'b1);
    step();
    vec++;
    if (err_cnt_o !== 16'd1) begin
      errs++;
      $display("FAIL cnt_rd: got %0d want 1", err_cnt_o);
    end
    do_partial(10'd9, 64'hAA000000_00000000, 8'h80, m1, 1'b0);
    inject(10'd9, {par(m1) ^ 8'h80, m1});
    do_partial(10'd9, 64'h00000000_00000055, 8'h01, m2, 1'b1);
    step();
    vec++;
    if (err_cnt_o !== 16'd2) begin
      errs++;
      $display("FAIL cnt_pw: got %0d want 2", err_cnt_o);
    end
    do_read(10'd9, m2, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_write(10'd1, 64'h11111111_11111111);
    do_write(10'd2, 64'h22222222_22222222);
    step();
    req_i = 1; we_i = 1; addr_i = 10'd1;
    wdata_i = 64'hFFFFFFFF_FFFFABCD; strb_i = 8'h03; #1;
    vec++;
    if (gnt_o !== 0) begin
      errs++; $display("FAIL b2b_c0: gnt=%b want 0", gnt_o);
    end
    step(); #1;
    vec++;
    if (gnt_o !== 1 || rvalid_o !== 0) begin
      errs++; $display("FAIL b2b_c1: gnt=%b rv=%b want 1 0", gnt_o, rvalid_o);
    end
    step();
    addr_i = 10'd2; wdata_i = 64'h55660000_00000000; strb_i = 8'hC0; #1;
    vec++;
    if (gnt_o !== 0 || rvalid_o !== 1) begin
      errs++; $display("FAIL b2b_c2: gnt=%b rv=%b want 0 1", gnt_o, rvalid_o);
    end
    step(); #1;
    vec++;
    if (gnt_o !== 1 || rvalid_o !== 0 ||
        mem_wdata_o[DW-1:0] !== 64'h55662222_22222222) begin
      errs++;
      $display("FAIL b2b_c3: gnt=%b rv=%b wd=%h want 1 0 5566222222222222",
               gnt_o, rvalid_o, mem_wdata_o[DW-1:0]);
    end
    step();
    we_i = 0; addr_i = 10'd1; strb_i = '0; wdata_i = '0; #1;
    vec++;
    if (gnt_o !== 1 || rvalid_o !== 1) begin
      errs++; $display("FAIL b2b_c4: gnt=%b rv=%b want 1 1", gnt_o, rvalid_o);
    end
    step(); idle_in(); #1;
    vec++;
    if (rvalid_o !== 1 || rdata_o !== 64'h11111111_1111ABCD ||
        ecc_err_o !== 0) begin
      errs++;
      $display("FAIL b2b_c5: rv=%b rd=%h ecc=%b want 1 111111111111abcd 0",
               rvalid_o, rdata_o, ecc_err_o);
    end
  endtask

  task automatic test_empty_write();
    step();
    req_i = 1; we_i = 1; addr_i = 10'd3;
    wdata_i = 64'hCAFEF00D_CAFEF00D; strb_i = '0; #1;
    vec++;
    if (gnt_o !== 1 || mem_req_o !== 0) begin
      errs++;
      $display("FAIL empty_issue: gnt=%b mreq=%b want 1 0", gnt_o, mem_req_o);
    end
    step(); idle_in(); #1;
    vec++;
    if (rvalid_o !== 1 || rdata_o !== '0 || ecc_err_o !== 0 ||
        mem_req_o !== 0) begin
      errs++;
      $display("FAIL empty_rsp: rv=%b rd=%h ecc=%b mreq=%b want 1 0 0 0",
               rvalid_o, rdata_o, ecc_err_o, mem_req_o);
    end
  endtask

  task automatic test_reset_mid_rmw();
    step();
    req_i = 1; we_i = 1; addr_i = 10'd5;
    wdata_i = 64'h12345678_00000000; strb_i = 8'hF0; #1;
    vec++;
    if (gnt_o !== 0 || mem_req_o !== 1 || mem_we_o !== 0) begin
      errs++;
      $display("FAIL rst_rmw_c0: gnt=%b mreq=%b mwe=%b want 0 1 0",
               gnt_o, mem_req_o, mem_we_o);
    end
    step();
    idle_in(); rst_ni = 0; #1;
    vec++;
    if (mem_req_o !== 0 || mem_we_o !== 0 || gnt_o !== 0) begin
      errs++;
      $display("FAIL rst_rmw_c1: mreq=%b mwe=%b gnt=%b want 0 0 0",
               mem_req_o, mem_we_o, gnt_o);
    end
    step();
    vec++;
    if (rvalid_o !== 0 || err_cnt_o !== '0) begin
      errs++;
      $display("FAIL rst_rmw_c2: rv=%b cnt=%0d want 0 0", rvalid_o, err_cnt_o);
    end
    rst_ni = 1;
    do_read(10'd5, 64'hDEADBEEF_AABBCCDD, 1'b0);
  endtask

  initial begin
    vec = 0;
    errs = 0;
    test_reset();
    test_full_rw();
    test_partial();
    test_parity();
    test_back_to_back();
    test_empty_write();
    test_reset_mid_rmw();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
